// File: rtl/lbist_session.sv
// LBIST session sequencer: per-fault pattern budget, ORA drain window, global timeout and abort.
// Latency: start -> INIT next cycle -> RUN the cycle after; counts update on leaving NEXT.
// Backpressure: none; start is ignored while busy, abort/timeout pre-empt the current fault.
module lbist_session #(
  parameter int ERR_BITS     = 12,
  parameter int PAT_BITS     = 16,
  parameter int MAX_PATTERNS = 1000,
  parameter int DRAIN        = 2,
  parameter int TO_BITS      = 32,
  parameter int TIMEOUT      = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                tpg_end,
  input  logic                ora_res,
  input  logic                fil_end,
  output logic                sys_reset,
  output logic                tpg_reset,
  output logic                fil_inc,
  output logic                busy,
  output logic                done,
  output logic                timed_out,
  output logic                aborted,
  output logic [ERR_BITS-1:0] err_count,
  output logic [ERR_BITS-1:0] fault_count,
  output logic                all_detected
);

  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN_S, NEXT, DONE} state_t;

  localparam logic [PAT_BITS-1:0] PAT_LAST   = PAT_BITS'(MAX_PATTERNS - 1);
  localparam logic [3:0]          DRAIN_LAST = 4'((DRAIN == 0) ? 0 : DRAIN - 1);
  localparam logic [ERR_BITS-1:0] CNT_MAX    = '1;
  localparam logic [TO_BITS-1:0]  TO_LAST    = TO_BITS'(TIMEOUT - 1);
  localparam bit                  TO_EN      = (TIMEOUT != 0);

  state_t              state, state_nx;
  logic [PAT_BITS-1:0] pat_cnt;
  logic [3:0]          drn_cnt;
  logic [TO_BITS-1:0]  cyc_cnt;
  logic                det;
  logic                busy_st;
  logic                to_hit;
  logic                kill;
  logic                accept;

  assign busy_st = (state == INIT) || (state == RUN) || (state == DRAIN_S) || (state == NEXT);
  // cyc_cnt holds the number of cycles since the start cycle, so the session ends
  // exactly TIMEOUT cycles after start was sampled.
  assign to_hit  = TO_EN && busy_st && (cyc_cnt == TO_LAST);
  assign kill    = busy_st && (abort || to_hit);
  assign accept  = ((state == IDLE) || (state == DONE)) && start;

  // Next-state decode; abort/timeout override any in-flight transition.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = INIT;
      INIT:       state_nx = RUN;
      RUN: begin
        if (ora_res)                                state_nx = NEXT;
        else if (tpg_end || (pat_cnt == PAT_LAST)) state_nx = (DRAIN == 0) ? NEXT : DRAIN_S;
      end
      DRAIN_S:    if (drn_cnt == DRAIN_LAST) state_nx = NEXT;
      NEXT:       state_nx = fil_end ? DONE : RUN;
      default:    state_nx = IDLE;
    endcase
    if (kill) state_nx = DONE;
  end

  // State register; fil_inc is registered so it lands on the first cycle of the next fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      fil_inc <= 1'b0;
    end else begin
      state   <= state_nx;
      fil_inc <= (state == NEXT) && (state_nx == RUN);
    end
  end

  // Per-fault pattern/drain counters, detection flag and session cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_cnt <= '0;
      drn_cnt <= '0;
      det     <= 1'b0;
      cyc_cnt <= '0;
    end else if (accept) begin
      pat_cnt <= '0;
      drn_cnt <= '0;
      det     <= 1'b0;
      cyc_cnt <= TO_BITS'(1);
    end else begin
      if (busy_st) cyc_cnt <= cyc_cnt + 1'b1;
      case (state)
        RUN: begin
          pat_cnt <= pat_cnt + 1'b1;
          if (ora_res) det <= 1'b1;
        end
        DRAIN_S: begin
          drn_cnt <= drn_cnt + 1'b1;
          if (ora_res) det <= 1'b1;
        end
        NEXT: begin
          pat_cnt <= '0;
          drn_cnt <= '0;
          det     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Saturating coverage counts and end-of-session cause flags; a killed fault is not counted.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      err_count   <= '0;
      fault_count <= '0;
      timed_out   <= 1'b0;
      aborted     <= 1'b0;
    end else if (kill) begin
      aborted   <= abort;
      timed_out <= !abort;
    end else if (state == NEXT) begin
      if (fault_count != CNT_MAX)       fault_count <= fault_count + 1'b1;
      if (det && (err_count != CNT_MAX)) err_count  <= err_count + 1'b1;
    end
  end

  assign busy         = busy_st;
  assign done         = (state == DONE);
  assign sys_reset    = (state == INIT);
  assign tpg_reset    = (state != RUN);
  assign all_detected = done && (err_count == fault_count);

endmodule
